// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: latches frame geometry, gates the pixel streams around conv2d_3x3 and reports completion.
module conv_frame_sequencer #(
  parameter int DWIDTH  = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              new_frame,
  input  logic [CNT_W-1:0]  cfg_start_row,
  input  logic [CNT_W-1:0]  cfg_stop_row,
  input  logic [CNT_W-1:0]  cfg_col_num,
  input  logic [DWIDTH-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DWIDTH-1:0] k_in_tdata,
  output logic              k_in_tvalid,
  input  logic              k_in_tready,
  input  logic [DWIDTH-1:0] k_out_tdata,
  input  logic              k_out_tvalid,
  output logic              k_out_tready,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_timeout,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  in_row_cnt,
  output logic [CNT_W-1:0]  out_row_cnt
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  localparam int WD_W = $clog2(TIMEOUT);
  state_t state;
  logic [CNT_W-1:0] rows_m1, cols_m1, in_col, out_col;
  logic [WD_W-1:0] wd;
  logic out_done, feed, open, in_hs, out_hs, in_wrap, out_wrap, in_end, out_end, bad;
  assign feed = state == FEED;
  assign open = feed || state == DRAIN;
  assign busy = open;
  assign k_in_tdata = s_tdata;
  assign k_in_tvalid = s_tvalid && feed;
  assign s_tready = k_in_tready && feed;
  assign m_tdata = k_out_tdata;
  assign m_tvalid = k_out_tvalid && open;
  assign k_out_tready = m_tready && open;
  assign in_hs = s_tvalid && s_tready;
  assign out_hs = k_out_tvalid && k_out_tready;
  assign in_wrap = in_col == cols_m1;
  assign out_wrap = out_col == cols_m1;
  assign in_end = in_hs && in_wrap && in_row_cnt == rows_m1;
  assign out_end = out_hs && out_wrap && out_row_cnt == rows_m1;
  assign m_tlast = open && out_wrap;
  assign m_tuser = open && out_row_cnt == '0 && out_col == '0;
  assign bad = cfg_stop_row <= cfg_start_row || cfg_col_num == '0;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      rows_m1 <= '0;
      cols_m1 <= '0;
      in_col <= '0;
      out_col <= '0;
      in_row_cnt <= '0;
      out_row_cnt <= '0;
      wd <= '0;
      out_done <= 1'b0;
      frame_done <= 1'b0;
      frame_timeout <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_timeout <= 1'b0;
      cfg_err <= 1'b0;
      if (in_hs) begin
        in_col <= in_wrap ? '0 : in_col + CNT_W'(1);
        if (in_wrap) in_row_cnt <= in_row_cnt + CNT_W'(1);
      end
      if (out_hs) begin
        out_col <= out_wrap ? '0 : out_col + CNT_W'(1);
        if (out_wrap) out_row_cnt <= out_row_cnt + CNT_W'(1);
      end
      wd <= (state == DRAIN && !out_hs) ? wd + WD_W'(1) : '0;
      case (state)
        IDLE: if (new_frame) begin
          rows_m1 <= cfg_stop_row - cfg_start_row - CNT_W'(1);
          cols_m1 <= cfg_col_num - CNT_W'(1);
          cfg_err <= bad;
          if (!bad) begin
            state <= FEED;
            in_col <= '0;
            out_col <= '0;
            in_row_cnt <= '0;
            out_row_cnt <= '0;
            out_done <= 1'b0;
          end
        end
        FEED: if (in_end) begin
          state <= (out_done || out_end) ? DONE : DRAIN;
          frame_done <= out_done || out_end;
        end else if (out_end) out_done <= 1'b1;
        // watchdog fires on the edge where the idle count reaches TIMEOUT-1
        DRAIN: if (out_end) begin
          state <= DONE;
          frame_done <= 1'b1;
        end else if (!out_hs && wd == WD_W'(TIMEOUT - 2)) begin
          state <= DONE;
          frame_timeout <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: directed frames against a count-based frame model with a 3-cycle kernel stand-in.
module tb_conv_frame_sequencer;
  localparam int TMO = 16;
  logic sys_clk = 1'b0, sys_rst, new_frame;
  logic [15:0] cfg_start_row, cfg_stop_row, cfg_col_num;
  logic [15:0] s_tdata, k_in_tdata, k_out_tdata, m_tdata, in_row_cnt, out_row_cnt;
  logic s_tvalid, s_tready, k_in_tvalid, k_in_tready, k_out_tvalid, k_out_tready;
  logic m_tvalid, m_tready, m_tlast, m_tuser, busy, frame_done, frame_timeout, cfg_err;

  conv_frame_sequencer #(.DWIDTH(16), .CNT_W(16), .TIMEOUT(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .new_frame(new_frame),
    .cfg_start_row(cfg_start_row), .cfg_stop_row(cfg_stop_row), .cfg_col_num(cfg_col_num),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .k_in_tdata(k_in_tdata), .k_in_tvalid(k_in_tvalid), .k_in_tready(k_in_tready),
    .k_out_tdata(k_out_tdata), .k_out_tvalid(k_out_tvalid), .k_out_tready(k_out_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .busy(busy), .frame_done(frame_done), .frame_timeout(frame_timeout), .cfg_err(cfg_err),
    .in_row_cnt(in_row_cnt), .out_row_cnt(out_row_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // environment: pixel source, kernel stand-in (3-cycle latency, x ^ 5A5A) and sink
  int cyc = 0, src_idx = 0, emitted = 0, emit_lim = 1000;
  logic [15:0] src_base = '0;
  bit src_en = 0, tog = 0;
  logic [15:0] kq[$];
  int kt[$];

  task automatic drive();
    s_tvalid = src_en;
    s_tdata = 16'(src_base + 16'(src_idx));
    k_out_tvalid = 1'b0;
    k_out_tdata = '0;
    if (kq.size() > 0) begin
      k_out_tvalid = emitted < emit_lim && kt[0] <= cyc;
      k_out_tdata = kq[0] ^ 16'h5A5A;
    end
    m_tready = tog ? cyc[0] : 1'b1;
  endtask

  task automatic cycle();
    logic ihs, ohs;
    int c;
    @(negedge sys_clk);
    ihs = k_in_tvalid && k_in_tready;
    ohs = k_out_tvalid && k_out_tready;
    @(posedge sys_clk);
    #1;
    c = cyc;
    cyc++;
    if (ohs) begin
      void'(kq.pop_front());
      void'(kt.pop_front());
      emitted++;
    end
    if (ihs) begin
      kq.push_back(k_in_tdata);
      kt.push_back(c + 3);
      src_idx++;
    end
    drive();
  endtask

  // frame model: open/feed/drain derived from beat counts only
  bit chk_on = 0, open = 0, x_done = 0, x_to = 0, x_err = 0;
  int in_cnt = 0, out_cnt = 0, total = 0, m_cols = 1, idle = 0, ncyc = 0;
  logic [15:0] base = '0;
  int beats = 0, tlasts = 0, tusers = 0, done_cnt = 0, to_cnt = 0, err_cnt = 0;
  int last_beat = 0, to_gap = 0, beats_at_done = 0;

  always @(negedge sys_clk) begin
    bit feed, ib, ob, was_close;
    if (chk_on) begin
      ncyc++;
      feed = open && in_cnt < total;
      ib = feed && s_tvalid && k_in_tready;
      ob = open && k_out_tvalid && m_tready;
      chk("busy", busy, open);
      chk("s_tready", s_tready, feed && k_in_tready);
      chk("k_in_tvalid", k_in_tvalid, feed && s_tvalid);
      chk("k_in_tdata", k_in_tdata, s_tdata);
      chk("m_tvalid", m_tvalid, open && k_out_tvalid);
      chk("k_out_tready", k_out_tready, open && m_tready);
      chk("m_tdata", m_tdata, k_out_tdata);
      chk("m_tlast", m_tlast, open && (out_cnt % m_cols) == m_cols - 1);
      chk("m_tuser", m_tuser, open && out_cnt == 0);
      chk("frame_done", frame_done, x_done);
      chk("frame_timeout", frame_timeout, x_to);
      chk("cfg_err", cfg_err, x_err);
      chk("in_row_cnt", in_row_cnt, in_cnt / m_cols);
      chk("out_row_cnt", out_row_cnt, out_cnt / m_cols);
      if (ob) chk("beat_data", m_tdata, (16'(base + 16'(out_cnt))) ^ 16'h5A5A);
      if (m_tvalid && m_tready) begin
        beats++;
        tlasts += int'(m_tlast);
        tusers += int'(m_tuser);
        last_beat = ncyc;
      end
      if (frame_done) begin
        done_cnt++;
        beats_at_done = beats;
      end
      if (frame_timeout) begin
        to_cnt++;
        to_gap = ncyc - last_beat;
      end
      if (cfg_err) err_cnt++;
      was_close = x_done || x_to;
      x_done = 0;
      x_to = 0;
      x_err = 0;
      if (sys_rst) begin
        open = 0;
        in_cnt = 0;
        out_cnt = 0;
        total = 0;
        m_cols = 1;
      end else if (open) begin
        in_cnt += int'(ib);
        out_cnt += int'(ob);
        if (!feed) idle = ob ? 0 : idle + 1;
        if (in_cnt == total && out_cnt == total) begin
          open = 0;
          x_done = 1;
        end else if (idle == TMO - 1) begin
          open = 0;
          x_to = 1;
        end
      end else if (new_frame && !was_close) begin
        if (cfg_stop_row <= cfg_start_row || cfg_col_num == 0) x_err = 1;
        else begin
          open = 1;
          m_cols = int'(cfg_col_num);
          total = (int'(cfg_stop_row) - int'(cfg_start_row)) * m_cols;
          in_cnt = 0;
          out_cnt = 0;
          idle = 0;
          base = src_base;
        end
      end
    end
  end

  task automatic clear_stats();
    beats = 0; tlasts = 0; tusers = 0; done_cnt = 0; to_cnt = 0; err_cnt = 0; beats_at_done = 0; to_gap = 0;
  endtask

  task automatic start_frame(int start, int stop, int cols, logic [15:0] b);
    src_base = b;
    src_idx = 0;
    emitted = 0;
    src_en = 1;
    cfg_start_row = 16'(start);
    cfg_stop_row = 16'(stop);
    cfg_col_num = 16'(cols);
    new_frame = 1;
    drive();
    cycle();
    new_frame = 0;
  endtask

  task automatic run_frame(int lim);
    int i = 0;
    while (done_cnt + to_cnt == 0 && i < lim) begin
      cycle();
      i++;
    end
    chk("frame_closed", done_cnt + to_cnt > 0, 1);
    cycle();
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    sys_rst = 1; new_frame = 0; cfg_start_row = '0; cfg_stop_row = '0; cfg_col_num = '0; k_in_tready = 1;
    drive();
    cycle();
    chk_on = 1;
    cycle();
    chk("rst_busy", busy, 0);
    chk("rst_m_tuser", m_tuser, 0);
    chk("rst_k_out_tready", k_out_tready, 0);
    sys_rst = 0;
    cycle();
    // basic 4x5 frame
    clear_stats();
    start_frame(0, 4, 5, 16'h0100);
    run_frame(200);
    chk("basic_inputs", src_idx, 20);
    chk("basic_beats", beats, 20);
    chk("basic_tlast", tlasts, 4);
    chk("basic_tuser", tusers, 1);
    chk("basic_done", done_cnt, 1);
    chk("basic_out_rows", out_row_cnt, 4);
    // sink backpressure
    clear_stats();
    tog = 1;
    start_frame(0, 4, 5, 16'h0200);
    run_frame(300);
    tog = 0;
    chk("bp_beats", beats, 20);
    chk("bp_done", done_cnt, 1);
    chk("bp_beats_at_done", beats_at_done, 20);
    // rejected geometry
    clear_stats();
    start_frame(8, 8, 5, 16'h0300);
    repeat (4) cycle();
    chk("err_pulses", err_cnt, 1);
    chk("err_busy", busy, 0);
    chk("err_s_tready", s_tready, 0);
    chk("err_inputs", src_idx, 0);
    // request while busy
    clear_stats();
    start_frame(0, 4, 5, 16'h0400);
    repeat (4) cycle();
    new_frame = 1;
    cycle();
    new_frame = 0;
    run_frame(200);
    chk("busyreq_beats", beats, 20);
    chk("busyreq_done", done_cnt, 1);
    chk("busyreq_err", err_cnt, 0);
    // reset mid-frame after 7 inputs
    clear_stats();
    start_frame(0, 4, 5, 16'h0500);
    i = 0;
    while (src_idx < 7 && i < 50) begin
      cycle();
      i++;
    end
    chk("rstmid_inputs", src_idx, 7);
    src_en = 0;
    sys_rst = 1;
    drive();
    cycle();
    sys_rst = 0;
    kq.delete();
    kt.delete();
    drive();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_in_rows", in_row_cnt, 0);
    chk("rstmid_s_tready", s_tready, 0);
    cycle();
    chk("rstmid_no_pulse", done_cnt + to_cnt, 0);
    clear_stats();
    start_frame(2, 4, 3, 16'h0600);
    run_frame(100);
    chk("rstmid_beats", beats, 6);
    chk("rstmid_done", done_cnt, 1);
    chk("rstmid_timeout", to_cnt, 0);
    chk("rstmid_out_rows", out_row_cnt, 2);
    // watchdog: kernel withholds the last pixel
    clear_stats();
    emit_lim = 19;
    start_frame(0, 4, 5, 16'h0700);
    run_frame(200);
    chk("wd_timeout", to_cnt, 1);
    chk("wd_done", done_cnt, 0);
    chk("wd_beats", beats, 19);
    chk("wd_gap", to_gap, 16);
    chk("wd_idle_busy", busy, 0);
    emit_lim = 1000;
    kq.delete();
    kt.delete();
    src_en = 0;
    drive();
    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller placed around the `conv2d_3x3` HLS kernel. It latches a per-frame geometry on a `new_frame` request, then gates the pixel source into the kernel's AXI-stream input and the kernel's output into the downstream sink. It counts rows and columns on both sides, marks output row ends (`m_tlast`) and the frame start (`m_tuser`), and reports frame completion, configuration errors and drain timeouts. Inputs are admitted only while a frame is open, so the kernel never sees stray pixels between frames.

## Interface
- `DWIDTH`, 16, pixel width on every stream.
- `CNT_W`, 16, width of the row and column fields and counters.
- `TIMEOUT`, 4096, number of idle cycles in DRAIN before the frame is forced closed.
- `sys_clk` in 1: the single clock.
- `sys_rst` in 1: reset, synchronous and active-high.
- `new_frame` in 1: frame request pulse; sampled only in IDLE.
- `cfg_start_row`, `cfg_stop_row` in CNT_W each: row range, half-open [start, stop).
- `cfg_col_num` in CNT_W: pixels per row.
- `s_tdata` in DWIDTH, `s_tvalid` in 1, `s_tready` out 1: pixel source.
- `k_in_tdata` out DWIDTH, `k_in_tvalid` out 1, `k_in_tready` in 1: to kernel `input_r`.
- `k_out_tdata` in DWIDTH, `k_out_tvalid` in 1, `k_out_tready` out 1: from kernel `output_r`.
- `m_tdata` out DWIDTH, `m_tvalid` out 1, `m_tready` in 1: filtered sink.
- `m_tlast` out 1: last pixel of an output row.
- `m_tuser` out 1: first output pixel of the frame.
- `busy` out 1: a frame is open.
- `frame_done` out 1: one-cycle pulse when a frame closes normally.
- `frame_timeout` out 1: one-cycle pulse when a frame is closed by the watchdog.
- `cfg_err` out 1: one-cycle pulse when a frame request is rejected.
- `in_row_cnt`, `out_row_cnt` out CNT_W: rows completed on each side in the current frame.

## Operation
- States are IDLE, FEED, DRAIN and DONE.
- **IDLE, `new_frame`=1:**
  - Latch the configuration as `rows = stop - start` (CNT_W bits) and `cols = cfg_col_num`.
  - If `stop <= start` or `cols == 0`: stay in IDLE and pulse `cfg_err` on the next cycle.
  - Otherwise clear all counters and go to FEED.
- `new_frame` outside IDLE is ignored. It does not queue and does not raise an error.
- Input path is combinational pass-through, qualified by state:
  - `k_in_tdata = s_tdata`.
  - `k_in_tvalid = s_tvalid & (state==FEED)`.
  - `s_tready = k_in_tready & (state==FEED)`.
- Output path is combinational pass-through, qualified by state:
  - `m_tdata = k_out_tdata`.
  - `m_tvalid = k_out_tvalid & (state in {FEED, DRAIN})`.
  - `k_out_tready = m_tready & (state in {FEED, DRAIN})`.
- Input counters advance on the `k_in` handshake:
  - The column counter wraps at `cols-1`; `in_row_cnt` increments on each wrap.
  - The handshake at row `rows-1`, column `cols-1` ends input: go to DRAIN.
- Output counters advance on the `m` handshake, with the same wrap rule.
  - `m_tlast` = (output column == `cols-1`).
  - `m_tuser` = (output row==0 and column==0).
  - The handshake at row `rows-1`, column `cols-1` completes output.
- Output complete while in DRAIN: go to DONE.
- Output complete in the same cycle as input complete (or earlier, while still in FEED): go straight to DONE once input completes.
- **Watchdog:** in DRAIN a cycle counter increments on each cycle with no `m` handshake and clears on every handshake. When it reaches `TIMEOUT-1`, go to DONE with the timeout flag set.
- **DONE:**
  - Lasts one cycle and returns to IDLE.
  - Pulses `frame_done`, or `frame_timeout` instead when the timeout flag is set.
  - `busy` is 0 in DONE.
- Output beats arriving in IDLE or DONE are held off (`k_out_tready`=0). They are not dropped.

## Timing
- **Reset:**
  - State is IDLE and every counter is 0.
  - `busy`, `frame_done`, `frame_timeout`, `cfg_err`, `s_tready`, `k_in_tvalid`, `k_out_tready`, `m_tvalid`, `m_tlast` and `m_tuser` are all 0.
  - `m_tdata` and `k_in_tdata` follow their inputs.
- **Reset mid-frame:** on the first edge with `sys_rst`=1 the state becomes IDLE. Gating deasserts in that same cycle after the edge, and no done or timeout pulse is produced.
- **Frame start:** `new_frame` at edge N gives FEED and `busy`=1 from edge N+1; `cfg_err` is likewise visible from N+1.
- **Latency:** data paths add zero cycles. `frame_done` is high in the cycle after the final output handshake.
- **Counter arithmetic:** counters saturate at neither end. The column compare is `== cols-1` computed in CNT_W bits. `in_row_cnt` and `out_row_cnt` hold their final values until the next accepted frame.

## Test plan
- **Basic frame:**
  - Stimulus: start=0, stop=4, cols=5; source and sink always ready; kernel model with 3-cycle delay.
  - Required: 20 inputs accepted; `m_tlast` on output beats 5/10/15/20; `m_tuser` on beat 1 only; `frame_done` exactly once; `out_row_cnt`=4.
- **Backpressure:**
  - Stimulus: same frame with `m_tready` toggling every other cycle.
  - Required: no beat lost or duplicated; `k_out_tready` mirrors `m_tready`; `frame_done` only after beat 20.
- **Config error:**
  - Stimulus: start=8, stop=8, cols=5.
  - Required: `cfg_err` pulses one cycle; `busy` stays 0; `s_tready`=0.
- **Request while busy:**
  - Stimulus: `new_frame` pulsed in FEED.
  - Required: ignored; the frame finishes with 20 outputs and one `frame_done`.
- **Watchdog:**
  - Stimulus: `TIMEOUT`=16; kernel model emits only 19 outputs.
  - Required: `frame_timeout` pulses 16 cycles after the last output handshake; no `frame_done`; IDLE follows.
- **Reset mid-frame:**
  - Stimulus: `sys_rst` for 1 cycle after 7 inputs, then a new 2x3 frame.
  - Required: all outputs return to reset values; the new frame gives 6 outputs and a clean `frame_done`.
